pipe_stall_ctrl: RTL and testbench

Pipeline stall controller and multi-cycle EX sequencer for the five-stage core. It merges the load-use stall request from ID with multi-cycle EX operations (madd/msub, div) into the 6-bit `stall` vector that every pipeline register consumes. It tracks the EX operation's cycle index so EX can sequence its partial results, and keeps a saturating stall-cycle counter for performance analysis.

---
 rtl/pipe_stall_ctrl.sv | 96 +++++++++
 tb/tb_pipe_stall_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: merges the ID load-use stall with multi-cycle EX ops,
// sequences the EX cycle index and keeps a saturating stall-cycle counter.
module pipe_stall_ctrl #(
  parameter int CNT_W  = 6,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id,
  input  logic              ex_mc_req,
  input  logic [CNT_W-1:0]  ex_mc_len,
  input  logic              ex_mc_abort,
  output logic [5:0]        stall,
  output logic [CNT_W-1:0]  ex_mc_cnt,
  output logic              ex_mc_done,
  output logic [PERF_W-1:0] stall_cycles
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [5:0] STALL_EX = 6'b001111;
  localparam logic [5:0] STALL_ID = 6'b000111;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] len_q, len_nx;
  logic [5:0]       id_stall;

  assign id_stall = stallreq_id ? STALL_ID : 6'b000000;

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    len_nx     = len_q;
    stall      = '0;
    ex_mc_cnt  = '0;
    ex_mc_done = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (ex_mc_req && (ex_mc_len != '0)) begin
            stall    = STALL_EX;
            state_nx = RUN;
            cnt_nx   = CNT_W'(1);
            len_nx   = ex_mc_len;
          end else begin
            // zero-length op completes in its acceptance cycle
            stall      = id_stall;
            ex_mc_done = ex_mc_req;
          end
        end
        RUN: begin
          ex_mc_cnt = cnt;
          if (ex_mc_abort || !ex_mc_req) begin
            stall    = id_stall;
            state_nx = IDLE;
            cnt_nx   = '0;
          end else if (cnt < len_q) begin
            stall  = STALL_EX;
            cnt_nx = cnt + CNT_W'(1);
          end else begin
            stall      = id_stall;
            ex_mc_done = 1'b1;
            state_nx   = IDLE;
            cnt_nx     = '0;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      len_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      len_q <= len_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall[0] && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: op-timeline model checked every cycle, plus directed
// scenarios with hand-computed literal expectations.
module tb_pipe_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stallreq_id = 1'b0;
  logic       ex_mc_req = 1'b0;
  logic       ex_mc_abort = 1'b0;
  logic [5:0] ex_mc_len = 6'd0;

  logic [5:0]  stall, ex_mc_cnt;
  logic        ex_mc_done;
  logic [31:0] stall_cycles;

  logic [5:0]  s_stall, s_cnt;
  logic        s_done;
  logic [3:0]  s_cycles;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.CNT_W(6), .PERF_W(32)) dut (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_mc_req(ex_mc_req),
    .ex_mc_len(ex_mc_len), .ex_mc_abort(ex_mc_abort), .stall(stall),
    .ex_mc_cnt(ex_mc_cnt), .ex_mc_done(ex_mc_done), .stall_cycles(stall_cycles)
  );

  // narrow counter instance so saturation is reachable quickly
  pipe_stall_ctrl #(.CNT_W(6), .PERF_W(4)) dut_s (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_mc_req(ex_mc_req),
    .ex_mc_len(ex_mc_len), .ex_mc_abort(ex_mc_abort), .stall(s_stall),
    .ex_mc_cnt(s_cnt), .ex_mc_done(s_done), .stall_cycles(s_cycles)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model: an op is described by its acceptance cycle and length; outputs follow
  // from the elapsed cycle count k (EX stall for k<N, done at k==N).
  bit          m_active = 1'b0;
  int          m_start = 0;
  int          m_len = 0;
  int          cyc = 0;
  logic [63:0] m_perf = 64'd0;

  always @(negedge clk) begin
    logic [5:0] es;
    logic [5:0] ec;
    logic       ed;
    logic [5:0] idp;
    int         k;
    idp = stallreq_id ? 6'b000111 : 6'b000000;
    es = 6'd0; ec = 6'd0; ed = 1'b0;
    if (rst) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (ex_mc_req && ex_mc_len > 0) begin
        es = 6'b001111;
        m_active = 1'b1;
        m_start = cyc;
        m_len = int'(ex_mc_len);
      end else begin
        es = idp;
        ed = ex_mc_req;
      end
    end else begin
      k = cyc - m_start;
      ec = 6'(k);
      if (ex_mc_abort || !ex_mc_req) begin
        es = idp;
        m_active = 1'b0;
      end else if (k < m_len) begin
        es = 6'b001111;
      end else begin
        es = idp;
        ed = 1'b1;
        m_active = 1'b0;
      end
    end
    chk("model_stall", {58'd0, stall}, {58'd0, es});
    chk("model_cnt", {58'd0, ex_mc_cnt}, {58'd0, ec});
    chk("model_done", {63'd0, ex_mc_done}, {63'd0, ed});
    chk("model_stall_cycles", {32'd0, stall_cycles}, m_perf);
    chk("model_sat_cycles", {60'd0, s_cycles}, (m_perf > 64'd15) ? 64'd15 : m_perf);
    chk("model_sat_stall", {58'd0, s_stall}, {58'd0, es});
    if (rst) m_perf = 64'd0;
    else if (es[0] && m_perf < 64'hFFFF_FFFF) m_perf = m_perf + 64'd1;
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stallreq_id = 1'b0; ex_mc_req = 1'b0; ex_mc_abort = 1'b0; ex_mc_len = 6'd0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    step();
    step();
    // reset mid-RUN
    rst = 1'b0; ex_mc_req = 1'b1; ex_mc_len = 6'd5;
    step(); step(); step();
    @(negedge clk);
    chk("run_cnt3", {58'd0, ex_mc_cnt}, 64'd3);
    chk("run_stall", {58'd0, stall}, 64'h0F);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_stall", {58'd0, stall}, 64'd0);
    chk("rst_cnt", {58'd0, ex_mc_cnt}, 64'd0);
    step();
    @(negedge clk);
    chk("rst2_stall", {58'd0, stall}, 64'd0);
    chk("rst2_done", {63'd0, ex_mc_done}, 64'd0);
    step();
    rst = 1'b0; ex_mc_req = 1'b0;
    @(negedge clk);
    chk("post_rst_cycles", {32'd0, stall_cycles}, 64'd0);
    chk("post_rst_cnt", {58'd0, ex_mc_cnt}, 64'd0);

    // load-use only
    do_reset();
    stallreq_id = 1'b1;
    @(negedge clk);
    chk("lu_stall", {58'd0, stall}, 64'h07);
    step();
    stallreq_id = 1'b0;
    @(negedge clk);
    chk("lu_after", {58'd0, stall}, 64'd0);
    chk("lu_cycles", {32'd0, stall_cycles}, 64'd1);

    // multi-cycle len 2
    do_reset();
    ex_mc_req = 1'b1; ex_mc_len = 6'd2;
    @(negedge clk);
    chk("mc_c0_stall", {58'd0, stall}, 64'h0F);
    chk("mc_c0_cnt", {58'd0, ex_mc_cnt}, 64'd0);
    step();
    @(negedge clk);
    chk("mc_c1_cnt", {58'd0, ex_mc_cnt}, 64'd1);
    step();
    @(negedge clk);
    chk("mc_done", {63'd0, ex_mc_done}, 64'd1);
    chk("mc_done_cnt", {58'd0, ex_mc_cnt}, 64'd2);
    chk("mc_done_stall", {58'd0, stall}, 64'd0);
    step();
    ex_mc_req = 1'b0;
    @(negedge clk);
    chk("mc_cycles", {32'd0, stall_cycles}, 64'd2);

    // overlap with load-use
    do_reset();
    stallreq_id = 1'b1; ex_mc_req = 1'b1; ex_mc_len = 6'd3;
    step(); step(); step();
    @(negedge clk);
    chk("ov_done_stall", {58'd0, stall}, 64'h07);
    chk("ov_done", {63'd0, ex_mc_done}, 64'd1);
    step();
    stallreq_id = 1'b0; ex_mc_req = 1'b0;
    @(negedge clk);
    chk("ov_cycles", {32'd0, stall_cycles}, 64'd4);

    // abort at cnt 4
    do_reset();
    ex_mc_req = 1'b1; ex_mc_len = 6'd10;
    step(); step(); step(); step();
    ex_mc_abort = 1'b1;
    @(negedge clk);
    chk("ab_cnt", {58'd0, ex_mc_cnt}, 64'd4);
    chk("ab_stall", {58'd0, stall}, 64'd0);
    chk("ab_done", {63'd0, ex_mc_done}, 64'd0);
    step();
    ex_mc_abort = 1'b0; ex_mc_req = 1'b0;
    @(negedge clk);
    chk("ab_idle_cnt", {58'd0, ex_mc_cnt}, 64'd0);

    // zero length, then back-to-back ops
    do_reset();
    ex_mc_req = 1'b1; ex_mc_len = 6'd0;
    @(negedge clk);
    chk("z_done", {63'd0, ex_mc_done}, 64'd1);
    chk("z_stall", {58'd0, stall}, 64'd0);
    step();
    ex_mc_len = 6'd1;
    step();
    ex_mc_len = 6'd2;
    @(negedge clk);
    chk("b2b_first_done", {63'd0, ex_mc_done}, 64'd1);
    step();
    @(negedge clk);
    chk("b2b_second_accept", {58'd0, stall}, 64'h0F);
    chk("b2b_second_cnt", {58'd0, ex_mc_cnt}, 64'd0);
    step(); step(); step();
    ex_mc_req = 1'b0;

    // saturation on narrow counter; len change during RUN ignored
    do_reset();
    ex_mc_req = 1'b1; ex_mc_len = 6'd20;
    step();
    ex_mc_len = 6'd1;
    for (int i = 0; i < 19; i++) step();
    @(negedge clk);
    chk("sat_done", {63'd0, ex_mc_done}, 64'd1);
    step();
    ex_mc_req = 1'b0;
    @(negedge clk);
    chk("sat_narrow", {60'd0, s_cycles}, 64'hF);
    chk("sat_wide", {32'd0, stall_cycles}, 64'd20);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
